// File: rtl/vpu_strip_engine.sv
// vpu_strip_engine: strip-mined vector engine with a private register file.
// Element-wise ops (ADD/SUB/MIN/MAX/AND/OR/XOR) and reductions (RSUM/RMAX)
// of length 0..VLMAX are processed one LANES-wide chunk per cycle.
// Optional build macro VPU_SAT_EN: ADD, SUB and RSUM saturate instead of
// wrapping on signed overflow (OVERFLOW status is reported either way).
module vpu_strip_engine #(
  parameter int LANES     = 8,
  parameter int ELEM_W    = 32,
  parameter int VLMAX     = 32,
  parameter int NUM_VREGS = 8,
  parameter int RW        = $clog2(NUM_VREGS),
  parameter int IW        = $clog2(VLMAX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [RW-1:0]     cmd_vs1,
  input  logic [RW-1:0]     cmd_vs2,
  input  logic [RW-1:0]     cmd_vd,
  input  logic [15:0]       cmd_vl,
  input  logic              cmd_masked,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_reg,
  input  logic [IW-1:0]     wr_idx,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic [RW-1:0]     rd_reg,
  input  logic [IW-1:0]     rd_idx,
  output logic [ELEM_W-1:0] rd_data,
  output logic              done,
  output logic [1:0]        done_status,
  output logic [ELEM_W-1:0] red_result,
  output logic              busy,
  output logic              error
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0, OP_SUB = 4'd1, OP_MIN = 4'd2, OP_MAX  = 4'd3,
    OP_AND  = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_RSUM = 4'd7,
    OP_RMAX = 4'd8
  } op_t;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_OVF    = 2'b01;
  localparam logic [1:0] ST_BAD_VL = 2'b10;
  localparam logic [1:0] ST_BAD_OP = 2'b11;

  localparam logic [ELEM_W-1:0] SMAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] SMIN = {1'b1, {(ELEM_W-1){1'b0}}};

  // Signed add/subtract returning {overflow, result}; saturates when enabled.
  function automatic logic [ELEM_W:0] addsub(input logic [ELEM_W-1:0] a,
                                             input logic [ELEM_W-1:0] b,
                                             input logic              sub);
    logic [ELEM_W-1:0] bb;
    logic [ELEM_W-1:0] s;
    logic              ovf;
    bb  = sub ? ~b : b;
    s   = a + bb + ELEM_W'(sub);
    ovf = (a[ELEM_W-1] == bb[ELEM_W-1]) && (s[ELEM_W-1] != a[ELEM_W-1]);
`ifdef VPU_SAT_EN
    if (ovf) s = a[ELEM_W-1] ? SMIN : SMAX;
`endif
    return {ovf, s};
  endfunction

  state_t              r_state, w_state_nxt;
  logic [ELEM_W-1:0]   r_vrf [NUM_VREGS][VLMAX];
  op_t                 r_op;
  logic [RW-1:0]       r_vs1, r_vs2, r_vd;
  logic [15:0]         r_vl;
  logic                r_masked;
  logic [IW-1:0]       r_base;
  logic [ELEM_W-1:0]   r_acc;
  logic                r_ovf;
  logic                r_done;
  logic [1:0]          r_status;
  logic [ELEM_W-1:0]   r_red;
  logic                r_err;
  logic [ELEM_W-1:0]   r_rd;

  logic                w_accept, w_bad_op, w_bad_vl, w_zero_vl, w_cmd_red;
  logic [ELEM_W-1:0]   w_cmd_init;
  logic                w_is_red, w_last;
  logic [IW-1:0]       w_idx [LANES];
  logic [ELEM_W-1:0]   w_a   [LANES];
  logic [ELEM_W-1:0]   w_b   [LANES];
  logic [ELEM_W:0]     w_sum [LANES];
  logic [ELEM_W:0]     w_rs  [LANES];
  logic                w_act [LANES];
  logic [ELEM_W-1:0]   w_acc;
  logic                w_ovf;
  logic                w_red_wr;
  logic [RW-1:0]       w_red_vd;
  logic [ELEM_W-1:0]   w_red_val;

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign done_status = r_status;
  assign red_result  = r_red;
  assign error       = r_err;
  assign rd_data     = r_rd;

  // Command decode and validation at the accept point.
  always_comb begin
    w_accept   = cmd_valid && (r_state == S_IDLE);
    w_bad_op   = (cmd_op > 4'd8);
    w_bad_vl   = (cmd_vl > 16'(VLMAX));
    w_zero_vl  = (cmd_vl == 16'd0);
    w_cmd_red  = (cmd_op == OP_RSUM) || (cmd_op == OP_RMAX);
    w_cmd_init = (cmd_op == OP_RMAX) ? SMIN : '0;
    w_is_red   = (r_op == OP_RSUM) || (r_op == OP_RMAX);
    w_last     = (17'(r_base) + 17'(LANES)) >= 17'(r_vl);
  end

  // Lane datapath for the current chunk, including the reduction chain.
  // NOTE: every combinational output gets a default before any branch so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_acc = r_acc;
    w_ovf = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_idx[l] = r_base + IW'(l);
      w_a[l]   = r_vrf[r_vs1][w_idx[l]];
      w_b[l]   = r_vrf[r_vs2][w_idx[l]];
      w_act[l] = (16'(w_idx[l]) < r_vl) && (!r_masked || r_vrf[0][w_idx[l]][0]);
      w_rs[l]  = '0;
      case (r_op)
        OP_ADD:  w_sum[l] = addsub(w_a[l], w_b[l], 1'b0);
        OP_SUB:  w_sum[l] = addsub(w_a[l], w_b[l], 1'b1);
        OP_MIN:  w_sum[l] = {1'b0, ($signed(w_a[l]) < $signed(w_b[l])) ? w_a[l] : w_b[l]};
        OP_MAX:  w_sum[l] = {1'b0, ($signed(w_a[l]) > $signed(w_b[l])) ? w_a[l] : w_b[l]};
        OP_AND:  w_sum[l] = {1'b0, w_a[l] & w_b[l]};
        OP_OR:   w_sum[l] = {1'b0, w_a[l] | w_b[l]};
        OP_XOR:  w_sum[l] = {1'b0, w_a[l] ^ w_b[l]};
        default: w_sum[l] = '0;
      endcase
      if (w_act[l]) begin
        if (r_op == OP_RSUM) begin
          w_rs[l] = addsub(w_acc, w_a[l], 1'b0);
          w_acc   = w_rs[l][ELEM_W-1:0];
          w_ovf   = w_ovf | w_rs[l][ELEM_W];
        end else if (r_op == OP_RMAX) begin
          if ($signed(w_a[l]) > $signed(w_acc)) w_acc = w_a[l];
        end else begin
          w_ovf = w_ovf | w_sum[l][ELEM_W];
        end
      end
    end
  end

  // Reduction result write to vd[0]: at the final chunk, or at accept for vl == 0.
  always_comb begin
    w_red_wr  = 1'b0;
    w_red_vd  = r_vd;
    w_red_val = w_acc;
    if (r_state == S_EXEC && w_is_red && w_last) begin
      w_red_wr = 1'b1;
    end else if (w_accept && !w_bad_op && !w_bad_vl && w_zero_vl && w_cmd_red) begin
      w_red_wr  = 1'b1;
      w_red_vd  = cmd_vd;
      w_red_val = w_cmd_init;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_bad_op || w_bad_vl || w_zero_vl) ? S_DONE : S_EXEC;
      S_EXEC: if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Vector register file: host writes in IDLE, lane writes in EXEC, reduction write.
  // NOTE: the register file is reset element by element because every element
  // must read back as zero after reset; it is built from flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VREGS; v++)
        for (int e = 0; e < VLMAX; e++)
          r_vrf[v][e] <= '0;
    end else begin
      if (r_state == S_IDLE && wr_en) r_vrf[wr_reg][wr_idx] <= wr_data;
      if (r_state == S_EXEC && !w_is_red) begin
        for (int l = 0; l < LANES; l++)
          if (w_act[l]) r_vrf[r_vd][w_idx[l]] <= w_sum[l][ELEM_W-1:0];
      end
      if (w_red_wr) r_vrf[w_red_vd][0] <= w_red_val;
    end
  end

  // Command latch, chunk counter, accumulator and completion reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_ADD;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_vd     <= '0;
      r_vl     <= '0;
      r_masked <= 1'b0;
      r_base   <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_status <= ST_OK;
      r_red    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op     <= op_t'(cmd_op);
        r_vs1    <= cmd_vs1;
        r_vs2    <= cmd_vs2;
        r_vd     <= cmd_vd;
        r_vl     <= cmd_vl;
        r_masked <= cmd_masked;
        r_base   <= '0;
        r_acc    <= w_cmd_init;
        r_ovf    <= 1'b0;
        r_err    <= w_bad_op || w_bad_vl;
        if (w_bad_op || w_bad_vl) begin
          r_done   <= 1'b1;
          r_status <= w_bad_op ? ST_BAD_OP : ST_BAD_VL;
        end else if (w_zero_vl) begin
          r_done   <= 1'b1;
          r_status <= ST_OK;
          if (w_cmd_red) r_red <= w_cmd_init;
        end
      end else if (r_state == S_EXEC) begin
        r_base <= r_base + IW'(LANES);
        r_acc  <= w_acc;
        r_ovf  <= r_ovf | w_ovf;
        if (w_last) begin
          r_done   <= 1'b1;
          r_status <= (r_ovf | w_ovf) ? ST_OVF : ST_OK;
          if (w_is_red) r_red <= w_acc;
        end
      end
    end
  end

  // Always-live read port; a same-cycle write is not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd <= '0;
    else        r_rd <= r_vrf[rd_reg][rd_idx];
  end

endmodule
